// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//   MEM->WB pipeline register plus the writeback stage. Captures the MEM-stage
//   control, load data, ALU result, destination register and PC+4, selects the
//   writeback value and drives the register-file write port. Also keeps a
//   retired-instruction counter.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active low
//   *_M          MEM-stage instruction fields (RegWrite, ResultSrc, ReadData,
//                ALUResult, rd, PCPlus4, Valid)
//   Stall_W      hold every WB register this cycle
//   Flush_W      load a bubble into WB this cycle (wins over Stall_W)
//   RegWrite_W   register-file write enable (never asserted for x0)
//   rd_W         register-file write address
//   Result_W     register-file write data / forwarding value
//   Valid_W      WB holds a real instruction
//   InstRet      retired-instruction count (wraps silently)
// -----------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RegWrite_M,
    input  logic [1:0]       ResultSrc_M,
    input  logic [XLEN-1:0]  ReadData_M,
    input  logic [XLEN-1:0]  ALUResult_M,
    input  logic [4:0]       rd_M,
    input  logic [XLEN-1:0]  PCPlus4_M,
    input  logic             Valid_M,
    input  logic             Stall_W,
    input  logic             Flush_W,
    output logic             RegWrite_W,
    output logic [4:0]       rd_W,
    output logic [XLEN-1:0]  Result_W,
    output logic             Valid_W,
    output logic [CNT_W-1:0] InstRet
);

    logic             valid_q,     valid_d;
    logic             regwrite_q,  regwrite_d;
    logic [1:0]       src_q,       src_d;
    logic [XLEN-1:0]  read_data_q, read_data_d;
    logic [XLEN-1:0]  alu_q,       alu_d;
    logic [4:0]       rd_q,        rd_d;
    logic [XLEN-1:0]  pc4_q,       pc4_d;
    logic [CNT_W-1:0] instret_q,   instret_d;

    // An instruction leaves WB whenever it is valid and not held. A flush on
    // the same edge only replaces what follows it, so it still retires.
    logic retire;
    assign retire = valid_q & ~Stall_W;

    always_comb begin
        valid_d     = valid_q;
        regwrite_d  = regwrite_q;
        src_d       = src_q;
        read_data_d = read_data_q;
        alu_d       = alu_q;
        rd_d        = rd_q;
        pc4_d       = pc4_q;
        if (Flush_W) begin
            valid_d     = 1'b0;
            regwrite_d  = 1'b0;
            src_d       = 2'b00;
            read_data_d = '0;
            alu_d       = '0;
            rd_d        = 5'd0;
            pc4_d       = '0;
        end else if (!Stall_W) begin
            valid_d     = Valid_M;
            // Bubbles from MEM must never write, whatever their RegWrite bit.
            regwrite_d  = RegWrite_M & Valid_M;
            src_d       = ResultSrc_M;
            read_data_d = ReadData_M;
            alu_d       = ALUResult_M;
            rd_d        = rd_M;
            pc4_d       = PCPlus4_M;
        end
        instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q     <= 1'b0;
            regwrite_q  <= 1'b0;
            src_q       <= 2'b00;
            read_data_q <= '0;
            alu_q       <= '0;
            rd_q        <= 5'd0;
            pc4_q       <= '0;
            instret_q   <= '0;
        end else begin
            valid_q     <= valid_d;
            regwrite_q  <= regwrite_d;
            src_q       <= src_d;
            read_data_q <= read_data_d;
            alu_q       <= alu_d;
            rd_q        <= rd_d;
            pc4_q       <= pc4_d;
            instret_q   <= instret_d;
        end
    end

    // Result select works only on registered fields, so nothing from the MEM
    // inputs reaches the WB outputs combinationally. Code 11 aliases ALU.
    always_comb begin
        case (src_q)
            2'b01:   Result_W = read_data_q;
            2'b10:   Result_W = pc4_q;
            default: Result_W = alu_q;
        endcase
    end

    assign Valid_W    = valid_q;
    assign rd_W       = rd_q;
    assign RegWrite_W = regwrite_q & valid_q & (rd_q != 5'd0);
    assign InstRet    = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            RegWrite_M = 1'b0;
    logic [1:0]      ResultSrc_M = 2'b00;
    logic [XLEN-1:0] ReadData_M = '0;
    logic [XLEN-1:0] ALUResult_M = '0;
    logic [4:0]      rd_M = 5'd0;
    logic [XLEN-1:0] PCPlus4_M = '0;
    logic            Valid_M = 1'b0;
    logic            Stall_W = 1'b0;
    logic            Flush_W = 1'b0;

    logic            RegWrite_W,  RegWrite_W4;
    logic [4:0]      rd_W,        rd_W4;
    logic [XLEN-1:0] Result_W,    Result_W4;
    logic            Valid_W,     Valid_W4;
    logic [63:0]     InstRet;
    logic [3:0]      InstRet4;

    mem_wb_stage #(.XLEN(XLEN), .CNT_W(64)) dut (
        .clk(clk), .rst(rst), .RegWrite_M(RegWrite_M), .ResultSrc_M(ResultSrc_M),
        .ReadData_M(ReadData_M), .ALUResult_M(ALUResult_M), .rd_M(rd_M),
        .PCPlus4_M(PCPlus4_M), .Valid_M(Valid_M), .Stall_W(Stall_W),
        .Flush_W(Flush_W), .RegWrite_W(RegWrite_W), .rd_W(rd_W),
        .Result_W(Result_W), .Valid_W(Valid_W), .InstRet(InstRet)
    );

    // Narrow-counter copy on the same stimulus, used for the wrap behaviour.
    mem_wb_stage #(.XLEN(XLEN), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .RegWrite_M(RegWrite_M), .ResultSrc_M(ResultSrc_M),
        .ReadData_M(ReadData_M), .ALUResult_M(ALUResult_M), .rd_M(rd_M),
        .PCPlus4_M(PCPlus4_M), .Valid_M(Valid_M), .Stall_W(Stall_W),
        .Flush_W(Flush_W), .RegWrite_W(RegWrite_W4), .rd_W(rd_W4),
        .Result_W(Result_W4), .Valid_W(Valid_W4), .InstRet(InstRet4)
    );

    always #5 clk = ~clk;

    // Model: the instruction currently sitting in WB, plus a retire count.
    typedef struct {
        bit        valid;
        bit        wr;
        bit [1:0]  src;
        bit [4:0]  rd;
        bit [31:0] alu;
        bit [31:0] ld;
        bit [31:0] pc4;
    } wb_t;

    wb_t         m;
    longint unsigned m_cnt;
    int          total = 0;
    int          bad   = 0;

    function automatic wb_t empty_wb();
        wb_t e;
        e.valid = 0; e.wr = 0; e.src = 0; e.rd = 0; e.alu = 0; e.ld = 0; e.pc4 = 0;
        return e;
    endfunction

    function automatic bit [31:0] exp_result(wb_t w);
        if (w.src == 2'd1) return w.ld;
        if (w.src == 2'd2) return w.pc4;
        return w.alu;
    endfunction

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " Valid_W"},    Valid_W, m.valid);
        chk({tag, " RegWrite_W"}, RegWrite_W, m.valid && m.wr && (m.rd != 0));
        chk({tag, " rd_W"},       rd_W, m.rd);
        chk({tag, " Result_W"},   Result_W, exp_result(m));
        chk({tag, " InstRet"},    InstRet, m_cnt);
        chk({tag, " InstRet4"},   InstRet4, m_cnt % 16);
    endtask

    task automatic model_reset();
        m = empty_wb();
        m_cnt = 0;
    endtask

    // One clock: the model advances with the inputs present at the edge, and
    // the outputs are compared 1 time unit later.
    task automatic step(input string tag);
        @(posedge clk);
        if (rst) begin
            if (m.valid && !Stall_W) m_cnt++;
            if (Flush_W) m = empty_wb();
            else if (!Stall_W) begin
                m.valid = Valid_M;
                m.wr    = RegWrite_M && Valid_M;
                m.src   = ResultSrc_M;
                m.rd    = rd_M;
                m.alu   = ALUResult_M;
                m.ld    = ReadData_M;
                m.pc4   = PCPlus4_M;
            end
        end
        #1;
        check_all(tag);
        $display("cycle %s: valid=%0d we=%0d rd=%0d res=0x%08h instret=%0d",
                 tag, Valid_W, RegWrite_W, rd_W, Result_W, InstRet);
    endtask

    task automatic randomize_inputs();
        RegWrite_M  = 1'($urandom);
        ResultSrc_M = 2'($urandom);
        ReadData_M  = $urandom;
        ALUResult_M = $urandom;
        rd_M        = 5'($urandom);
        PCPlus4_M   = $urandom;
        Valid_M     = 1'($urandom);
    endtask

    task automatic set_basic(input logic [1:0] src, input logic [4:0] rd);
        ALUResult_M = 32'h10; ReadData_M = 32'hAB; PCPlus4_M = 32'h104;
        rd_M = rd; ResultSrc_M = src; RegWrite_M = 1'b1; Valid_M = 1'b1;
        Stall_W = 1'b0; Flush_W = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        model_reset();
        #1 check_all("reset");
        @(negedge clk);
        rst = 1'b1;
        #1 check_all("post-reset");
    endtask

    initial begin
        model_reset();
        // Reset held with random inputs, including stall/flush.
        for (int i = 0; i < 4; i++) begin
            randomize_inputs();
            Stall_W = 1'($urandom); Flush_W = 1'($urandom);
            step("in-reset");
        end
        @(negedge clk);
        randomize_inputs();
        Stall_W = 1'b1; Flush_W = 1'b0;
        rst = 1'b1;
        #1 check_all("released");
        chk("released literal Result_W", Result_W, 0);

        // Result select sweep with literal pins on the model.
        set_basic(2'b00, 5'd5); step("sweep00");
        chk("lit res00", Result_W, 32'h10);  chk("lit we00", RegWrite_W, 1);
        chk("lit rd00", rd_W, 5);            chk("lit cnt00", InstRet, 0);
        set_basic(2'b01, 5'd5); step("sweep01");
        chk("lit res01", Result_W, 32'hAB);  chk("lit cnt01", InstRet, 1);
        set_basic(2'b10, 5'd5); step("sweep10");
        chk("lit res10", Result_W, 32'h104); chk("lit cnt10", InstRet, 2);
        set_basic(2'b11, 5'd5); step("sweep11");
        chk("lit res11", Result_W, 32'h10);  chk("lit cnt11", InstRet, 3);

        // x0 suppression.
        set_basic(2'b00, 5'd0); step("x0");
        chk("lit x0 we", RegWrite_W, 0); chk("lit x0 valid", Valid_W, 1);
        step("x0-retire");
        chk("lit x0 cnt", InstRet, 5);

        // Stall three cycles with changing inputs, then stall+flush.
        set_basic(2'b00, 5'd7); step("cap7");
        for (int i = 0; i < 3; i++) begin
            randomize_inputs(); Stall_W = 1'b1; Flush_W = 1'b0;
            step("stall");
            chk("lit stall rd", rd_W, 7); chk("lit stall we", RegWrite_W, 1);
            chk("lit stall cnt", InstRet, 6);
        end
        Stall_W = 1'b1; Flush_W = 1'b1; step("stall+flush");
        chk("lit flush valid", Valid_W, 0); chk("lit flush we", RegWrite_W, 0);
        chk("lit flush rd", rd_W, 0);

        // Wrap of the 4-bit counter: 17 retirements after a fresh reset.
        do_reset();
        for (int i = 0; i < 18; i++) begin
            set_basic(2'($urandom), 5'($urandom)); step("wrap");
        end
        chk("lit wrap cnt4", InstRet4, 1);
        chk("lit wrap cnt64", InstRet, 17);

        // Randomized traffic with occasional asynchronous reset between edges.
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            Stall_W = ($urandom_range(0, 3) == 0);
            Flush_W = ($urandom_range(0, 6) == 0);
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
                chk("lit async cnt", InstRet, 0);
            end
            step("rand");
        end

        // Asynchronous reset mid-stream, checked before any clock edge.
        set_basic(2'b01, 5'd9); step("pre-async");
        #2 rst = 1'b0;
        model_reset();
        #1 check_all("async");
        chk("lit async valid", Valid_W, 0);
        chk("lit async instret", InstRet, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
